// File: rtl/deal_sequencer_pkg.sv
// Shared types and constants for the BlackJack round-start sequencer.
package bj_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    PAUSE,
    DONE,
    ERROR
  } seq_state_t;

  localparam logic TGT_PLAYER = 1'b0;
  localparam logic TGT_DEALER = 1'b1;

  localparam int RANK_W          = 4;
  localparam int RANK_MIN        = 1;
  localparam int RANK_MAX        = 13;
  localparam int DEALS_PER_ROUND = 4;

  function automatic logic rank_legal(input logic [RANK_W-1:0] rank);
    return (rank >= RANK_W'(RANK_MIN)) && (rank <= RANK_W'(RANK_MAX));
  endfunction

endpackage

// File: rtl/deal_sequencer_if.sv
// Card-source handshake and hand-logic deal strobe, bundled as one bus.
interface deal_sequencer_if;
  import bj_pkg::*;

  logic              card_req;
  logic              card_valid;
  logic [RANK_W-1:0] card_rank;
  logic              deal_valid;
  logic              deal_target;
  logic              deal_slot;
  logic [RANK_W-1:0] deal_rank;

  modport master (
    output card_req,
    input  card_valid,
    input  card_rank,
    output deal_valid,
    output deal_target,
    output deal_slot,
    output deal_rank
  );

  modport slave (
    input  card_req,
    output card_valid,
    output card_rank,
    input  deal_valid,
    input  deal_target,
    input  deal_slot,
    input  deal_rank
  );

endinterface

// File: rtl/deal_sequencer_interval_timer.sv
// Up-counter shared by the sequencer for both pause length and request timeout.
module interval_timer #(
  parameter int TIMER_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               enable,
  input  logic [TIMER_W-1:0] top,
  output logic               hit,
  output logic [TIMER_W-1:0] value
);

  assign hit = enable && (value == top - TIMER_W'(1));

  // Saturates on the last count rather than wrapping; the owner always clears on hit.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      value <= '0;
    end else if (enable && !hit) begin
      value <= value + TIMER_W'(1);
    end
  end

endmodule

// File: rtl/deal_sequencer.sv
// Round-start controller: requests four cards (P, D, P, D) with pause and timeout.
//   state | meaning
//   IDLE  | waiting for start
//   REQ   | card_req high, waiting for card_valid or timeout
//   PAUSE | gap between deals, first cycle carries deal_valid
//   DONE  | fourth card delivered, one cycle
//   ERROR | timeout or illegal rank, held until start or reset
module deal_sequencer
  import bj_pkg::*;
#(
  parameter int PAUSE_CYCLES   = 25_000_000,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TIMER_W        = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  deal_sequencer_if.master        bus,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam logic [TIMER_W-1:0] PAUSE_TOP   = TIMER_W'(PAUSE_CYCLES);
  localparam logic [TIMER_W-1:0] TIMEOUT_TOP = TIMER_W'(TIMEOUT_CYCLES);
  localparam logic [1:0]         LAST_IDX    = 2'(DEALS_PER_ROUND - 1);

  seq_state_t         state;
  logic [1:0]         idx;
  logic               tmr_clear;
  logic               tmr_enable;
  logic               tmr_hit;
  logic [TIMER_W-1:0] tmr_top;
  logic [TIMER_W-1:0] unused_tmr_value;
  logic               accept;
  logic               rank_ok;

  assign accept     = (state == REQ) && bus.card_valid;
  assign rank_ok    = rank_legal(bus.card_rank);
  assign tmr_enable = (state == REQ) || (state == PAUSE);
  assign tmr_top    = (state == PAUSE) ? PAUSE_TOP : TIMEOUT_TOP;
  // Every exit from REQ/PAUSE coincides with one of these, so the next timed state starts at 0.
  assign tmr_clear  = !tmr_enable || tmr_hit || accept || abort;

  interval_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .top    (tmr_top),
    .hit    (tmr_hit),
    .value  (unused_tmr_value)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      idx             <= '0;
      bus.card_req    <= 1'b0;
      bus.deal_valid  <= 1'b0;
      bus.deal_target <= TGT_PLAYER;
      bus.deal_slot   <= 1'b0;
      bus.deal_rank   <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
    end else begin
      bus.deal_valid <= 1'b0;
      done           <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state        <= REQ;
            idx          <= '0;
            bus.card_req <= 1'b1;
            busy         <= 1'b1;
          end
        end
        REQ: begin
          if (abort) begin
            state        <= IDLE;
            bus.card_req <= 1'b0;
            busy         <= 1'b0;
          end else if (bus.card_valid) begin
            bus.card_req <= 1'b0;
            if (rank_ok) begin
              bus.deal_valid  <= 1'b1;
              bus.deal_rank   <= bus.card_rank;
              bus.deal_target <= idx[0];
              bus.deal_slot   <= idx[1];
              if (idx == LAST_IDX) begin
                state <= DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                state <= PAUSE;
                idx   <= idx + 2'd1;
              end
            end else begin
              state <= ERROR;
              error <= 1'b1;
              busy  <= 1'b0;
            end
          end else if (tmr_hit) begin
            state        <= ERROR;
            error        <= 1'b1;
            busy         <= 1'b0;
            bus.card_req <= 1'b0;
          end
        end
        PAUSE: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (tmr_hit) begin
            state        <= REQ;
            bus.card_req <= 1'b1;
          end
        end
        DONE: begin
          if (!abort && start) begin
            state        <= REQ;
            idx          <= '0;
            bus.card_req <= 1'b1;
            busy         <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        ERROR: begin
          if (start) begin
            state        <= REQ;
            idx          <= '0;
            bus.card_req <= 1'b1;
            busy         <= 1'b1;
            error        <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_deal_sequencer.sv
// Randomized and directed bench for deal_sequencer against a per-card transaction model.
module tb_deal_sequencer;

  localparam int PAUSE   = 4;
  localparam int TIMEOUT = 8;

  logic clk;
  logic reset;
  logic start;
  logic abort;
  logic busy;
  logic done;
  logic error;

  deal_sequencer_if bus ();

  deal_sequencer #(
    .PAUSE_CYCLES   (PAUSE),
    .TIMEOUT_CYCLES (TIMEOUT),
    .TIMER_W        (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .abort (abort),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .error (error)
  );

  int checks = 0;
  int errors = 0;

  logic [3:0] ranks [4];
  int         dly   [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit legal(input logic [3:0] r);
    return (r >= 4'd1) && (r <= 4'd13);
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_req"},   32'(bus.card_req),   0);
    chk({tag, "_deal"},  32'(bus.deal_valid), 0);
    chk({tag, "_busy"},  32'(busy),           0);
    chk({tag, "_done"},  32'(done),           0);
    chk({tag, "_error"}, 32'(error),          0);
  endtask

  // Entry: first REQ cycle of card k. res: 0 next card pending, 1 error,
  // 2 round complete and idle, 3 round complete and restarted into REQ.
  task automatic serve(input int k, input logic [3:0] rank, input int delay,
                       input bit noise, input bit restart, output int res);
    bit acc;
    acc = 1'b0;
    res = 0;
    for (int c = 0; c < TIMEOUT && !acc; c++) begin
      chk("req_high", 32'(bus.card_req), 1);
      chk("req_no_deal", 32'(bus.deal_valid), 0);
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (c == delay) begin
        bus.card_valid = 1'b1;
        bus.card_rank  = rank;
        acc = 1'b1;
      end
      tick();
      bus.card_valid = 1'b0;
      bus.card_rank  = 4'($urandom);
    end
    start = 1'b0;
    if (!acc || !legal(rank)) begin
      chk("err_flag", 32'(error), 1);
      chk("err_req", 32'(bus.card_req), 0);
      chk("err_busy", 32'(busy), 0);
      chk("err_deal", 32'(bus.deal_valid), 0);
      chk("err_done", 32'(done), 0);
      res = 1;
      return;
    end
    chk("deal_valid", 32'(bus.deal_valid), 1);
    chk("deal_target", 32'(bus.deal_target), 32'(k % 2));
    chk("deal_slot", 32'(bus.deal_slot), 32'(k / 2));
    chk("deal_rank", 32'(bus.deal_rank), 32'(rank));
    chk("deal_done", 32'(done), (k == 3) ? 1 : 0);
    chk("deal_req", 32'(bus.card_req), 0);
    chk("deal_busy", 32'(busy), (k == 3) ? 0 : 1);
    if (k == 3) begin
      start = restart;
      tick();
      start = 1'b0;
      chk("post_done_req", 32'(bus.card_req), 32'(restart));
      chk("post_done_busy", 32'(busy), 32'(restart));
      chk("post_done_done", 32'(done), 0);
      chk("post_done_deal", 32'(bus.deal_valid), 0);
      res = restart ? 3 : 2;
    end else begin
      for (int p = 1; p < PAUSE; p++) begin
        start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
        chk("pause_req", 32'(bus.card_req), 0);
        chk("pause_deal", 32'(bus.deal_valid), 0);
        chk("pause_hold_rank", 32'(bus.deal_rank), 32'(rank));
        chk("pause_busy", 32'(busy), 1);
      end
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      start = 1'b0;
    end
  endtask

  task automatic run_round(input bit do_start, input bit noise, input bit restart, output int res);
    if (do_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_error_clr", 32'(error), 0);
    end
    res = 0;
    for (int k = 0; k < 4; k++) begin
      serve(k, ranks[k], dly[k], noise, restart && (k == 3), res);
      if (res == 1) break;
    end
  endtask

  task automatic hold_error();
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("error_held", 32'(error), 1);
      chk("error_req", 32'(bus.card_req), 0);
    end
  endtask

  initial begin
    int  res;
    int  exp_res;
    bit  in_req;
    bit  restart;

    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    bus.card_valid = 1'b0;
    bus.card_rank  = 4'd0;
    tick();
    tick();
    chk_quiet("reset");
    chk("reset_rank", 32'(bus.deal_rank), 0);
    reset = 1'b0;
    tick();

    // card_valid in IDLE is ignored
    bus.card_valid = 1'b1;
    bus.card_rank  = 4'd7;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_quiet("idle_valid");
    end
    bus.card_valid = 1'b0;

    // Normal round
    ranks = '{4'd10, 4'd6, 4'd1, 4'd13};
    dly   = '{2, 2, 2, 2};
    run_round(1'b1, 1'b0, 1'b0, res);
    chk("round1_res", 32'(res), 2);
    tick();
    chk_quiet("round1_after");

    // Timeout, then recovery round
    ranks = '{4'd2, 4'd3, 4'd4, 4'd5};
    dly   = '{TIMEOUT, 0, 0, 0};
    run_round(1'b1, 1'b0, 1'b0, res);
    chk("timeout_res", 32'(res), 1);
    hold_error();
    dly = '{0, 0, 0, 0};
    run_round(1'b1, 1'b0, 1'b0, res);
    chk("recover_res", 32'(res), 2);
    tick();
    chk_quiet("recover_after");

    // Illegal rank on the second card, 0 and then 14
    ranks = '{4'd9, 4'd0, 4'd4, 4'd5};
    dly   = '{1, 1, 1, 1};
    run_round(1'b1, 1'b0, 1'b0, res);
    chk("rank0_res", 32'(res), 1);
    hold_error();
    ranks[1] = 4'd14;
    run_round(1'b1, 1'b0, 1'b0, res);
    chk("rank14_res", 32'(res), 1);
    hold_error();

    // Acceptance on the last timeout cycle wins
    ranks = '{4'd11, 4'd12, 4'd13, 4'd1};
    dly   = '{TIMEOUT - 1, TIMEOUT - 1, TIMEOUT - 1, TIMEOUT - 1};
    run_round(1'b1, 1'b0, 1'b0, res);
    chk("boundary_res", 32'(res), 2);
    tick();

    // Randomized rounds with stray start pulses
    in_req = 1'b0;
    for (int r = 0; r < 24; r++) begin
      for (int k = 0; k < 4; k++) begin
        ranks[k] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(14, 16) % 16)
                                               : 4'($urandom_range(1, 13));
        dly[k]   = ($urandom_range(0, 11) == 0) ? TIMEOUT : int'($urandom_range(0, TIMEOUT - 1));
      end
      restart = 1'($urandom_range(0, 1));
      exp_res = restart ? 3 : 2;
      for (int k = 0; k < 4; k++) begin
        if (dly[k] >= TIMEOUT || !legal(ranks[k])) begin
          exp_res = 1;
          break;
        end
      end
      run_round(!in_req, 1'b1, restart, res);
      chk("rand_res", 32'(res), 32'(exp_res));
      in_req = (res == 3);
      if (res == 1) hold_error();
    end
    if (in_req) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
    end
    chk("rand_end_req", 32'(bus.card_req), 0);

    // Abort in PAUSE after the first deal
    start = 1'b1;
    tick();
    start = 1'b0;
    bus.card_valid = 1'b1;
    bus.card_rank  = 4'd5;
    tick();
    bus.card_valid = 1'b0;
    chk("abort_p_deal", 32'(bus.deal_valid), 1);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      chk_quiet("abort_pause");
      tick();
    end

    // Abort coincident with card_valid in REQ
    start = 1'b1;
    tick();
    start = 1'b0;
    bus.card_valid = 1'b1;
    bus.card_rank  = 4'd8;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    bus.card_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_quiet("abort_req");
      tick();
    end

    // Reset mid-REQ with card_valid high
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    bus.card_valid = 1'b1;
    bus.card_rank  = 4'd3;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.card_valid = 1'b0;
    chk_quiet("reset_req");
    chk("reset_req_rank", 32'(bus.deal_rank), 0);
    chk("reset_req_tgt", 32'(bus.deal_target), 0);
    tick();
    chk_quiet("reset_req_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
